pin_chain_sequencer: RTL



---
 rtl/pin_chain_pkg.sv | 54 +++++
 rtl/pin_chain_sequencer_pin_sync.sv | 24 ++
 rtl/pin_chain_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pin_chain_pkg.sv
// Shared types and constants for the pico-ice pin-chain self-test sequencer:
// FSM state encoding, LFSR parameters, LED colours and the walking-vector rule.
package pin_chain_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SETTLE      = 3'd1,
        CHECK       = 3'd2,
        LFSR_SETTLE = 3'd3,
        LFSR_CHECK  = 3'd4,
        DONE        = 3'd5
    } seq_state_e;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam int          LFSR_W       = 16;
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam int          LFSR_VECTORS = 32;

    localparam logic [2:0] LED_OFF   = 3'b000;
    localparam logic [2:0] LED_BLUE  = 3'b001;
    localparam logic [2:0] LED_GREEN = 3'b010;
    localparam logic [2:0] LED_RED   = 3'b100;
    localparam logic [2:0] LED_WHITE = 3'b111;

    localparam int MAX_CHAINS = 32;

    // Step k*2 drives a single 0 on chain k, step k*2+1 a single 1 on chain k.
    function automatic logic [MAX_CHAINS-1:0] walk_vec(input int step, input int n_chains);
        logic [MAX_CHAINS-1:0] vec;
        logic                  lvl;
        lvl = (step % 2) == 1;
        vec = '0;
        for (int i = 0; i < MAX_CHAINS; i++) begin
            if (i < n_chains) begin
                vec[i] = (i == step / 2) ? lvl : ~lvl;
            end
        end
        return vec;
    endfunction

    function automatic logic [2:0] idle_led(input logic pass, input logic any_fail);
        logic [2:0] led;
        if (pass) begin
            led = LED_GREEN;
        end else if (any_fail) begin
            led = LED_RED;
        end else begin
            led = LED_OFF;
        end
        return led;
    endfunction

endpackage

// File: rtl/pin_chain_sequencer_pin_sync.sv
// Two-flop synchronizer for the asynchronous chain return pins; both stages
// reset to zero.
module pin_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            q_o    <= '0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/pin_chain_sequencer.sv
// Pin-chain self-test sequencer: walking/complement vectors, settle, compare, fail mask.
// Optional pseudo-random phase is compiled in with `define PIN_CHAIN_SEQ_LFSR_EN.
module pin_chain_sequencer
    import pin_chain_pkg::*;
#(
    parameter int N_CHAINS      = 3,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                hold_i,
    input  logic                start_i,
    input  logic [N_CHAINS-1:0] chain_out_i,
    output logic [N_CHAINS-1:0] chain_in_o,
    output logic                chain_oe_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                pass_o,
    output logic [N_CHAINS-1:0] fail_mask_o,
    output logic [2:0]          led_rgb_o,
    output seq_state_e          state_o
);

    localparam int STEP_W = $clog2(2 * N_CHAINS + LFSR_VECTORS);
    localparam int CNT_W  = $clog2(SETTLE_CYCLES);

    localparam logic [STEP_W-1:0] LAST_WALK   = STEP_W'(2 * N_CHAINS - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 3) begin : g_settle_too_short
        $error("pin_chain_sequencer: SETTLE_CYCLES must be at least 3");
    end
    if (N_CHAINS < 1 || N_CHAINS > MAX_CHAINS) begin : g_chain_count_bad
        $error("pin_chain_sequencer: N_CHAINS out of range");
    end

    seq_state_e          state_q;
    logic [STEP_W-1:0]   step_q;
    logic [CNT_W-1:0]    settle_q;
    logic [N_CHAINS-1:0] sync_out;
    logic [N_CHAINS-1:0] mask_new;
    logic [N_CHAINS-1:0] walk_first;
    logic [N_CHAINS-1:0] walk_next;

    pin_sync #(
        .WIDTH(N_CHAINS)
    ) u_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (chain_out_i),
        .q_o  (sync_out)
    );

    // chain_in_o holds the vector under test through SETTLE and CHECK, so it
    // doubles as the reference for the comparison.
    always_comb begin
        mask_new   = fail_mask_o | (sync_out ^ chain_in_o);
        walk_first = N_CHAINS'(walk_vec(0, N_CHAINS));
        walk_next  = N_CHAINS'(walk_vec(int'(step_q) + 1, N_CHAINS));
    end

`ifdef PIN_CHAIN_SEQ_LFSR_EN
    localparam logic [STEP_W-1:0] LAST_LFSR = STEP_W'(2 * N_CHAINS + LFSR_VECTORS - 1);

    if (N_CHAINS > LFSR_W) begin : g_lfsr_too_narrow
        $error("pin_chain_sequencer: N_CHAINS exceeds LFSR width");
    end

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_next;

    always_comb begin
        lfsr_next = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end
`endif

    assign state_o = state_q;

    // Run protocol: start_i is a level seen only in IDLE; busy_o covers the
    // whole run; done_o pulses for exactly one cycle as busy_o falls, and
    // pass_o/fail_mask_o are stable from that cycle until the next start.
    // hold_i aborts from any state without a done_o pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            step_q      <= '0;
            settle_q    <= '0;
            chain_in_o  <= '0;
            chain_oe_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            fail_mask_o <= '0;
            led_rgb_o   <= LED_OFF;
`ifdef PIN_CHAIN_SEQ_LFSR_EN
            lfsr_q      <= LFSR_SEED;
`endif
        end else if (hold_i) begin
            state_q    <= IDLE;
            chain_oe_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            led_rgb_o  <= LED_WHITE;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q     <= SETTLE;
                        step_q      <= '0;
                        settle_q    <= SETTLE_LOAD;
                        chain_in_o  <= walk_first;
                        chain_oe_o  <= 1'b1;
                        busy_o      <= 1'b1;
                        pass_o      <= 1'b0;
                        fail_mask_o <= '0;
                        led_rgb_o   <= LED_BLUE;
`ifdef PIN_CHAIN_SEQ_LFSR_EN
                        lfsr_q      <= LFSR_SEED;
`endif
                    end else begin
                        led_rgb_o <= idle_led(pass_o, fail_mask_o != '0);
                    end
                end

                SETTLE: begin
                    if (settle_q == '0) begin
                        state_q <= CHECK;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end

                CHECK: begin
                    fail_mask_o <= mask_new;
                    settle_q    <= SETTLE_LOAD;
                    if (step_q != LAST_WALK) begin
                        step_q     <= step_q + 1'b1;
                        chain_in_o <= walk_next;
                        state_q    <= SETTLE;
                    end else begin
`ifdef PIN_CHAIN_SEQ_LFSR_EN
                        step_q     <= step_q + 1'b1;
                        chain_in_o <= lfsr_q[N_CHAINS-1:0];
                        state_q    <= LFSR_SETTLE;
`else
                        state_q    <= DONE;
                        done_o     <= 1'b1;
                        busy_o     <= 1'b0;
                        chain_oe_o <= 1'b0;
                        pass_o     <= (mask_new == '0);
                        led_rgb_o  <= (mask_new == '0) ? LED_GREEN : LED_RED;
`endif
                    end
                end

`ifdef PIN_CHAIN_SEQ_LFSR_EN
                LFSR_SETTLE: begin
                    if (settle_q == '0) begin
                        state_q <= LFSR_CHECK;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end

                LFSR_CHECK: begin
                    fail_mask_o <= mask_new;
                    settle_q    <= SETTLE_LOAD;
                    lfsr_q      <= lfsr_next;
                    if (step_q != LAST_LFSR) begin
                        step_q     <= step_q + 1'b1;
                        chain_in_o <= lfsr_next[N_CHAINS-1:0];
                        state_q    <= LFSR_SETTLE;
                    end else begin
                        state_q    <= DONE;
                        done_o     <= 1'b1;
                        busy_o     <= 1'b0;
                        chain_oe_o <= 1'b0;
                        pass_o     <= (mask_new == '0);
                        led_rgb_o  <= (mask_new == '0) ? LED_GREEN : LED_RED;
                    end
                end
`endif

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q    <= IDLE;
                    busy_o     <= 1'b0;
                    chain_oe_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
